// File: rtl/aes_pkg.sv
// Shared encodings for the iterative AES-128 encrypt datapath and its round sequencer.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  localparam logic [1:0] SEL_MID    = 2'd0;
  localparam logic [1:0] SEL_FINAL  = 2'd1;
  localparam logic [1:0] SEL_LOAD   = 2'd2;
  localparam logic [1:0] SEL_ROUND0 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROUND0 = 3'd1,
    ST_MID    = 3'd2,
    ST_FINAL  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/aes_round_sequencer.sv
// Handshaked, abortable round sequencer driving the AES-128 state/key registers and round muxes.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic [1:0]         dp_sel,
  output logic               dp_en,
  output logic [ROUND_W-1:0] round_num,
  output logic               out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic [ROUND_W-1:0] LAST_MID  = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] FINAL_RND = ROUND_W'(NUM_ROUNDS);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [ROUND_W-1:0] r_cnt;
  logic [ROUND_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    dp_sel      = SEL_LOAD;
    dp_en       = 1'b0;
    round_num   = '0;
    out_sel     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready  = 1'b1;
        dp_en     = in_valid;
        w_cnt_nxt = '0;
        if (in_valid) w_state_nxt = ST_ROUND0;
      end
      ST_ROUND0: begin
        dp_sel = SEL_ROUND0;
        busy   = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          dp_en       = 1'b1;
          w_state_nxt = ST_MID;
          w_cnt_nxt   = ROUND_W'(1);
        end
      end
      ST_MID: begin
        dp_sel    = SEL_MID;
        busy      = 1'b1;
        round_num = r_cnt;
        // Abort takes priority over the hand-off to the final round.
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          dp_en = 1'b1;
          if (r_cnt >= LAST_MID) begin
            w_state_nxt = ST_FINAL;
            w_cnt_nxt   = FINAL_RND;
          end else begin
            w_cnt_nxt = r_cnt + ROUND_W'(1);
          end
        end
      end
      ST_FINAL: begin
        dp_sel    = SEL_FINAL;
        busy      = 1'b1;
        round_num = FINAL_RND;
        w_cnt_nxt = '0;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          dp_en       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_sel   = 1'b1;
        in_ready  = out_ready;
        // Registers hold the ciphertext until it is consumed; a waiting block loads with zero bubble.
        dp_en     = out_ready & in_valid;
        w_cnt_nxt = '0;
        if (out_ready) w_state_nxt = in_valid ? ST_ROUND0 : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
